// File: rtl/line_cmd_scheduler_if.sv
// Command and rasterizer signal bundle for line_cmd_scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface line_cmd_scheduler_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_x0;
   logic [7:0] cmd_y0;
   logic [7:0] cmd_x1;
   logic [7:0] cmd_y1;
   logic [7:0] cmd_x2;
   logic [7:0] cmd_y2;
   logic [7:0] ras_x0;
   logic [7:0] ras_y0;
   logic [7:0] ras_x1;
   logic [7:0] ras_y1;
   logic       ras_start;
   logic       ras_reset_buff;
   logic       ras_done;

   modport slave (
      input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2, ras_done,
      output cmd_ready, ras_x0, ras_y0, ras_x1, ras_y1, ras_start, ras_reset_buff
   );

   modport master (
      output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2, ras_done,
      input  cmd_ready, ras_x0, ras_y0, ras_x1, ras_y1, ras_start, ras_reset_buff
   );
endinterface

// File: rtl/line_cmd_scheduler.sv
// Buffers LINE / TRIANGLE / CLEAR commands and sequences them onto the
// rasterizer's single-line interface, counting edges and flagging timeouts.
module line_cmd_scheduler #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 8192
) (
   input  logic                       clk,
   input  logic                       rst,
   line_cmd_scheduler_if.slave        bus,
   output logic                       busy,
   output logic [15:0]                edge_count,
   output logic                       err_timeout
);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [3:0] IDLE       = 4'd0;
   localparam logic [3:0] LOAD       = 4'd1;
   localparam logic [3:0] LINE_START = 4'd2;
   localparam logic [3:0] LINE_WAIT  = 4'd3;
   localparam logic [3:0] NEXT_EDGE  = 4'd4;
   localparam logic [3:0] CLR_SET    = 4'd5;
   localparam logic [3:0] CLR_HOLD   = 4'd6;
   localparam logic [3:0] CLR_REL    = 4'd7;
   localparam logic [3:0] CLR_SETTLE = 4'd8;

   localparam logic [1:0] OP_LINE  = 2'b00;
   localparam logic [1:0] OP_CLEAR = 2'b01;
   localparam logic [1:0] OP_TRI   = 2'b10;

   typedef struct packed {
      logic [1:0] op;
      logic [7:0] x0;
      logic [7:0] y0;
      logic [7:0] x1;
      logic [7:0] y1;
      logic [7:0] x2;
      logic [7:0] y2;
   } cmd_t;

   cmd_t          fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   cmd_t          head;
   cmd_t          wr_data;

   logic [3:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [15:0]   edge_q, edge_d;
   logic          err_q, err_d;
   logic          done_q;
   cmd_t          cur_q;
   cmd_t          src;
   logic [31:0]   edge_xy;

   logic [7:0]    ras_x0_q, ras_y0_q, ras_x1_q, ras_y1_q;
   logic          ras_start_q;
   logic          ras_reset_buff_q;

   // ---------------------------------------------------------------- FIFO
   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign push    = bus.cmd_valid && !full;
   assign pop     = (state_q == LOAD);
   assign head    = fifo_mem[rd_ptr_q];
   assign wr_data = {bus.cmd_op, bus.cmd_x0, bus.cmd_y0, bus.cmd_x1, bus.cmd_y1,
                     bus.cmd_x2, bus.cmd_y2};

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            idx_d = 2'd0;
            case (head.op)
               OP_LINE, OP_TRI: state_d = LINE_START;
               OP_CLEAR:        state_d = CLR_SET;
               default:         state_d = IDLE;
            endcase
         end
         LINE_START: begin
            cnt_d   = '0;
            state_d = LINE_WAIT;
         end
         LINE_WAIT: begin
            if (done_q) begin
               edge_d  = edge_q + 16'd1;
               state_d = NEXT_EDGE;
            end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         NEXT_EDGE: begin
            if ((cur_q.op == OP_TRI) && (idx_q < 2'd2)) begin
               idx_d   = idx_q + 2'd1;
               state_d = LINE_START;
            end else begin
               state_d = IDLE;
            end
         end
         CLR_SET:    state_d = CLR_HOLD;
         CLR_HOLD:   state_d = CLR_REL;
         CLR_REL:    state_d = CLR_SETTLE;
         CLR_SETTLE: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // In LOAD the working registers are not yet valid, so edge 0 comes from the FIFO head.
   always_comb begin
      src = (state_q == LOAD) ? head : cur_q;
      case (idx_d)
         2'd1:    edge_xy = {src.x1, src.y1, src.x2, src.y2};
         2'd2:    edge_xy = {src.x2, src.y2, src.x0, src.y0};
         default: edge_xy = {src.x0, src.y0, src.x1, src.y1};
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         edge_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         cur_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
         err_q   <= err_d;
         done_q  <= bus.ras_done;
         if (state_q == LOAD) begin
            cur_q <= head;
         end
      end
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ras_x0_q         <= '0;
         ras_y0_q         <= '0;
         ras_x1_q         <= '0;
         ras_y1_q         <= '0;
         ras_start_q      <= 1'b0;
         ras_reset_buff_q <= 1'b0;
      end else begin
         ras_start_q      <= (state_d == LINE_START) || (state_d == CLR_REL);
         ras_reset_buff_q <= (state_d == CLR_SET);
         if (state_d == LINE_START) begin
            {ras_x0_q, ras_y0_q, ras_x1_q, ras_y1_q} <= edge_xy;
         end
      end
   end

   assign bus.cmd_ready      = !full;
   assign bus.ras_x0         = ras_x0_q;
   assign bus.ras_y0         = ras_y0_q;
   assign bus.ras_x1         = ras_x1_q;
   assign bus.ras_y1         = ras_y1_q;
   assign bus.ras_start      = ras_start_q;
   assign bus.ras_reset_buff = ras_reset_buff_q;
   assign busy               = (state_q != IDLE) || !empty;
   assign edge_count         = edge_q;
   assign err_timeout        = err_q;
endmodule

// File: doc/line_cmd_scheduler.md
Name: line_cmd_scheduler

Overview:
- Command front-end for the line rasterizer. It buffers draw commands in a small FIFO: LINE, TRIANGLE (three edges) and CLEAR.
- It sequences them onto the rasterizer's single-command interface (coordinates, start, reset_buff, done), one line at a time.
- It holds the coordinates stable for the whole draw, generates the clear handshake, counts completed edges and flags rasterizer timeouts.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).
- TIMEOUT_CYCLES, 8192, maximum cycles waiting for ras_done per edge before abort.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO not full; a command is accepted when cmd_valid && cmd_ready at a clk edge.
- cmd_op  input  2  00 LINE, 01 CLEAR, 10 TRIANGLE, 11 reserved (accepted, discarded).
- cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2  input  8 each  vertices; v2 is used only by TRIANGLE.
- ras_x0, ras_y0, ras_x1, ras_y1  output  8 each  coordinates to the rasterizer (registered).
- ras_start  output  1  one-cycle start pulse (registered).
- ras_reset_buff  output  1  clear request (registered).
- ras_done  input  1  one-cycle completion pulse from the rasterizer.
- busy  output  1  FSM not in IDLE or FIFO non-empty.
- edge_count  output  16  edges completed since reset; wraps 65535->0.
- err_timeout  output  1  sticky; set on any edge timeout, cleared only by rst.

Behaviour:
- Reset values:
  - All ras_* outputs 0, busy 0, edge_count 0, err_timeout 0.
  - FIFO empty, so cmd_ready 1.
  - FSM in IDLE.
- Reset mid-operation aborts everything and flushes the FIFO. The rasterizer is reset separately.
- FIFO:
  - Stores op plus six coordinates.
  - cmd_ready = !full, combinational from the registered count.
  - A push when full is impossible.
  - A simultaneous push and pop with the FIFO non-full is allowed, and the count is unchanged.
- FSM states: IDLE, LOAD, LINE_START, LINE_WAIT, NEXT_EDGE, CLR_SET, CLR_HOLD, CLR_REL, CLR_SETTLE.
- IDLE: if the FIFO is non-empty, go to LOAD.
- LOAD: pop the head into working registers, then branch on op:
  - LINE: edge index 0, go to LINE_START.
  - TRIANGLE: edge index 0, go to LINE_START.
  - CLEAR: go to CLR_SET.
  - Reserved: go to IDLE.
- LINE_START:
  - ras_x0..ras_y1 are driven for the current edge. TRIANGLE edges are e0 = v0->v1, e1 = v1->v2, e2 = v2->v0. LINE uses v0->v1.
  - ras_start = 1 for exactly this cycle. Clear the timeout counter. Go to LINE_WAIT.
- LINE_WAIT:
  - ras_start = 0. Coordinates are held unchanged.
  - On ras_done: edge_count += 1, go to NEXT_EDGE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1: set err_timeout, drop the rest of the command, go to IDLE.
- NEXT_EDGE: for a TRIANGLE with edge index < 2, increment the index and go to LINE_START. Otherwise go to IDLE.
- Clear sequence (fixed 4 cycles):
  - CLR_SET: ras_reset_buff = 1.
  - CLR_HOLD: ras_reset_buff = 0.
  - CLR_REL: ras_start = 1 (releases the rasterizer from its clear state).
  - CLR_SETTLE: ras_start = 0.
  - Then go to IDLE.
  - ras_start and ras_reset_buff are never both 1 in the same cycle.
  - edge_count is not changed by CLEAR.
- ras_done outside LINE_WAIT is ignored.
- Coordinates are passed unmodified; the rasterizer performs its own modulo-64 wrap.
- A degenerate line (v0 == v1) is still issued and counted.
- Minimum latency:
  - Command accepted at edge N: LOAD in cycle N+1, ras_start high in cycle N+2.
  - ras_done seen at edge M: the next ras_start (next triangle edge) is high in cycle M+2.
- busy rises the cycle after the first accept and falls when IDLE is reached with the FIFO empty.

Test Plan:
- Reset, then LINE (2,3)->(10,7); the model asserts ras_done 12 cycles after ras_start. Required:
  - ras_start high for 1 cycle, 2 cycles after accept.
  - ras_x0=2, ras_y0=3, ras_x1=10, ras_y1=7 stable until done.
  - edge_count=1; busy returns to 0.
- TRIANGLE v0=(0,0), v1=(20,0), v2=(0,20). Required:
  - Three start pulses, with coordinates (0,0,20,0), then (20,0,0,20), then (0,20,0,0).
  - Each start is 2 cycles after the preceding done; edge_count=3.
- CLEAR. Required:
  - Exactly ras_reset_buff=1 for 1 cycle, then 1 idle cycle, then ras_start=1 for 1 cycle, then 1 settle cycle.
  - Never overlapping; edge_count unchanged.
- Push 5 back-to-back LINE commands with FIFO_DEPTH=4 while the first is drawing. Required:
  - cmd_ready drops to 0 when full and rises after the next pop.
  - All commands execute in order; edge_count=5.
- Timeout: TIMEOUT_CYCLES=16 and ras_done never asserted on a TRIANGLE. Required:
  - err_timeout=1 at cycle 16 of LINE_WAIT; remaining edges dropped.
  - A following LINE still executes; err_timeout stays 1.
- Assert rst during LINE_WAIT with 2 commands queued. Required:
  - All outputs return to reset values immediately; FIFO empty; cmd_ready=1.
  - No ras_start after reset release until a new command arrives.
